// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiply and restoring
// divide on operand magnitudes, one iteration per cycle, with a final sign fix-up.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hold,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;     // product upper half / partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;     // multiplier / dividend-quotient shift register
    logic [WIDTH:0]   opb_q, opb_d;     // multiplicand / divisor magnitude
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    // Operand magnitudes; MIN_INT maps to 2^(WIDTH-1), which still fits unsigned.
    logic             is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & a[WIDTH-1];
    assign b_neg     = is_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
    assign b_mag     = b_neg ? (~b + WIDTH'(1)) : b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH:0]     rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   hi_res, lo_res;

    // One iteration of the datapath plus the sign-fixed result it would produce.
    always_comb begin
        mul_sum   = rem_q + (quo_q[0] ? opb_q : '0);
        div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {1'b0, opb_q};

        if (is_div_q) begin
            if (!div_diff[WIDTH+1]) begin
                rem_step = div_diff[WIDTH:0];
                quo_step = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_step = div_shift;
                quo_step = {quo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            rem_step = {1'b0, mul_sum[WIDTH:1]};
            quo_step = {mul_sum[0], quo_q[WIDTH-1:1]};
        end

        prod_mag = {rem_step[WIDTH-1:0], quo_step};
        prod_fix = neg_res_q ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;
        quo_fix  = neg_res_q ? (~quo_step + WIDTH'(1)) : quo_step;
        rem_fix  = neg_rem_q ? (~rem_step[WIDTH-1:0] + WIDTH'(1)) : rem_step[WIDTH-1:0];

        // Divide by zero leaves |a| as remainder, so only the quotient needs forcing.
        if (is_div_q) begin
            hi_res = rem_fix;
            lo_res = div_zero_q ? '1 : quo_fix;
        end else begin
            hi_res = prod_fix[2*WIDTH-1:WIDTH];
            lo_res = prod_fix[WIDTH-1:0];
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        opb_d      = opb_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    rem_d      = '0;
                    is_div_d   = op[1];
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = op[1] & (b == '0);
                    quo_d      = op[1] ? a_mag : b_mag;
                    opb_d      = {1'b0, op[1] ? b_mag : a_mag};
                end
            end
            RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    hi_d    = hi_res;
                    lo_d    = lo_res;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                if (hold) begin
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush aborts from any state and leaves the result registers untouched.
        if (cancel) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            opb_q      <= opb_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign busy = ((state_q == IDLE) & start & ~cancel) | ((state_q == RUN) & ~cancel);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
